// File: rtl/rog_pkg.sv
// Shared types and constants for the random operand generator.
package rog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Galois step: shift right, fold the taps in when a one falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances only when step is high.
module lfsr16
  import rog_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] value
);

  if (SEED == 16'h0000) begin : g_seed_check
    $error("lfsr16: SEED must be non-zero");
  end

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign value = r_lfsr;

endmodule

// File: rtl/rand_operand_gen.sv
// Issues NUM_TXN pseudo-random (a, b, sel) operand sets per run over a
// valid/ready handshake, drawing one LFSR value per operand.
module rand_operand_gen
  import rog_pkg::*;
#(
  parameter int          WIDTH   = 2,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          NUM_TXN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_sel,
  output logic             busy,
  output logic             done,
  output logic [7:0]       txn_cnt
);

  if (WIDTH < 1 || WIDTH > 7) begin : g_width_check
    $error("rand_operand_gen: WIDTH must be in 1..7");
  end
  if (NUM_TXN < 1 || NUM_TXN > 255) begin : g_txn_check
    $error("rand_operand_gen: NUM_TXN must be in 1..255");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_xfer;
  logic             w_last;
  logic             w_load;
  logic [15:0]      w_lfsr;
  logic             r_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sel;
  logic [7:0]       r_cnt;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (w_load),
    .value (w_lfsr)
  );

  assign w_xfer = (r_state == RUN) && r_valid && out_ready;
  assign w_last = (r_cnt == 8'(NUM_TXN - 1));

  // Abort outranks completion; a coincident transfer is still counted below.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_xfer && w_last) begin
          w_state_nxt = DONE;
        end else if (w_xfer) begin
          w_load = 1'b1;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_valid <= (w_state_nxt == RUN);
      if (w_load) begin
        r_a   <= w_lfsr[WIDTH-1:0];
        r_b   <= w_lfsr[2*WIDTH-1:WIDTH];
        r_sel <= w_lfsr[15];
      end
      if (r_state == IDLE && start) begin
        r_cnt <= 8'd0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_sel   = r_sel;
  assign txn_cnt   = r_cnt;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_rand_operand_gen.sv
// Scoreboard bench for rand_operand_gen: default instance plus a WIDTH=7/NUM_TXN=1 instance.
module tb_rand_operand_gen;

  localparam int NT = 8;
  localparam logic [15:0] SEED_V = 16'hACE1;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       sel;
  } op_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid, out_sel, busy, done;
  logic [1:0] out_a, out_b;
  logic [7:0] txn_cnt;

  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic       ready2 = 1'b0;
  logic       valid2, sel2, busy2, done2;
  logic [6:0] a2, b2;
  logic [7:0] cnt2;

  always #5 clk = ~clk;

  rand_operand_gen u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_sel   (out_sel),
    .busy      (busy),
    .done      (done),
    .txn_cnt   (txn_cnt)
  );

  rand_operand_gen #(
    .WIDTH   (7),
    .NUM_TXN (1)
  ) u_dut7 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .abort     (abort2),
    .out_valid (valid2),
    .out_ready (ready2),
    .out_a     (a2),
    .out_b     (b2),
    .out_sel   (sel2),
    .busy      (busy2),
    .done      (done2),
    .txn_cnt   (cnt2)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int          m_state = 0;   // 0 idle, 1 run, 2 done
  int          m_cnt = 0;
  logic [15:0] m_lfsr = SEED_V;
  op_t         q[$];
  op_t         m_last = '0;

  function automatic logic [15:0] ref_adv(input logic [15:0] v);
    logic [15:0] t;
    t = {1'b0, v[15:1]};
    if (v[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  function automatic op_t ref_op(input logic [15:0] v);
    op_t o;
    o.a = v[1:0];
    o.b = v[3:2];
    o.sel = v[15];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt = 0;
    m_lfsr = SEED_V;
    q.delete();
    m_last = '0;
  endtask

  task automatic push_load();
    q.push_back(ref_op(m_lfsr));
    m_lfsr = ref_adv(m_lfsr);
  endtask

  // One clock: pop/compare on a transfer, advance the model, then check outputs after the edge.
  task automatic step();
    logic xfer;
    op_t  e;
    xfer = (m_state == 1) && out_ready;
    if (xfer) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("xfer_a", 32'(out_a), 32'(e.a));
        chk("xfer_b", 32'(out_b), 32'(e.b));
        chk("xfer_sel", 32'(out_sel), 32'(e.sel));
        m_last = e;
      end
    end
    case (m_state)
      0: if (start) begin
        push_load();
        m_cnt = 0;
        m_state = 1;
      end
      1: begin
        if (xfer) m_cnt++;
        if (abort) begin
          if (!xfer && q.size() > 0) m_last = q[0];
          q.delete();
          m_state = 0;
        end else if (xfer && m_cnt == NT) begin
          m_state = 2;
        end else if (xfer) begin
          push_load();
        end
      end
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_state == 1));
    chk("busy", 32'(busy), 32'(m_state == 1));
    chk("done", 32'(done), 32'(m_state == 2));
    chk("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
    if (m_state == 1 && q.size() > 0) begin
      chk("hold_ops", 32'({out_a, out_b, out_sel}), 32'({q[0].a, q[0].b, q[0].sel}));
    end else if (m_state != 1) begin
      chk("retain_ops", 32'({out_a, out_b, out_sel}), 32'({m_last.a, m_last.b, m_last.sel}));
    end
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_idle();
    int guard;
    guard = 0;
    while (m_state != 0 && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) chk("run_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ops"}, 32'({out_a, out_b, out_sel}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cnt"}, 32'(txn_cnt), 32'd0);
  endtask

  initial begin
    logic [15:0] v8;
    int          done_seen;

    // Reset held from time zero; outputs must already be cleared
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_reset");

    // Run 1: full run with ready high
    out_ready = 1'b1;
    kick();
    chk("r1_op0", 32'({out_a, out_b, out_sel}), 32'({2'd1, 2'd0, 1'b1}));
    step();
    chk("r1_op1", 32'({out_a, out_b, out_sel}), 32'({2'd0, 2'd0, 1'b1}));
    step();
    chk("r1_op2", 32'({out_a, out_b, out_sel}), 32'({2'd0, 2'd2, 1'b0}));
    done_seen = 0;
    while (m_state == 1) begin
      step();
      if (done) done_seen++;
    end
    chk("r1_done_pulse", 32'(done), 32'd1);
    chk("r1_cnt", 32'(txn_cnt), 32'd8);
    step();
    chk("r1_done_clear", 32'(done), 32'd0);
    chk("r1_cnt_hold", 32'(txn_cnt), 32'd8);

    // Abort in IDLE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Run 2: continuation from LFSR after 8 steps; start during RUN ignored
    v8 = SEED_V;
    for (int i = 0; i < 8; i++) v8 = ref_adv(v8);
    kick();
    chk("r2_first_op", 32'({out_a, out_b, out_sel}), 32'({v8[1:0], v8[3:2], v8[15]}));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("r2_busy_after_start", 32'(busy), 32'd1);
    run_to_idle();
    step();

    // Run 3: abort coincident with the transfer at txn_cnt=3
    kick();
    while (m_cnt < 3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_cnt", 32'(txn_cnt), 32'd4);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    step();
    chk("abort_no_done", 32'(done), 32'd0);

    // Run 4: asynchronous reset mid-run at txn_cnt=5
    kick();
    while (m_cnt < 5) step();
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #2;
    rst_n = 1'b1;
    step();

    // Run 5: reproduces the post-reset sequence, with 5 cycles of backpressure
    out_ready = 1'b0;
    kick();
    chk("r5_op0", 32'({out_a, out_b, out_sel}), 32'({2'd1, 2'd0, 1'b1}));
    for (int i = 0; i < 5; i++) step();
    chk("bp_hold_ops", 32'({out_a, out_b, out_sel}), 32'({2'd1, 2'd0, 1'b1}));
    chk("bp_hold_cnt", 32'(txn_cnt), 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_op1", 32'({out_a, out_b, out_sel}), 32'({2'd0, 2'd0, 1'b1}));
    run_to_idle();
    chk("r5_cnt", 32'(txn_cnt), 32'd8);

    // WIDTH=7, NUM_TXN=1 instance
    ready2 = 1'b1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    chk("w7_valid", 32'(valid2), 32'd1);
    chk("w7_a", 32'(a2), 32'h61);
    chk("w7_b", 32'(b2), 32'h59);
    chk("w7_sel", 32'(sel2), 32'd1);
    @(posedge clk);
    #1;
    chk("w7_done", 32'(done2), 32'd1);
    chk("w7_valid_off", 32'(valid2), 32'd0);
    chk("w7_cnt", 32'(cnt2), 32'd1);
    @(posedge clk);
    #1;
    chk("w7_done_clear", 32'(done2), 32'd0);
    chk("w7_cnt_hold", 32'(cnt2), 32'd1);
    chk("w7_a_retain", 32'(a2), 32'h61);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_operand_gen.md
RAND_OPERAND_GEN -- requirements
Module: rand_operand_gen

Interface
REQ-001 Parameter WIDTH, default 2, operand bit width; legal range 1..7.
REQ-002 Parameter SEED, default 16'hACE1, LFSR reset value; zero SHALL be rejected at elaboration.
REQ-003 Parameter NUM_TXN, default 8, operands issued per run; legal range 1..255.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle run request, honoured only in IDLE.
REQ-007 abort  in  1  synchronous run cancel, honoured only in RUN.
REQ-008 out_valid  out  1  operand set on out_a/out_b/out_sel is valid.
REQ-009 out_ready  in  1  downstream logic unit accepts the operand set.
REQ-010 out_a  out  WIDTH  operand a.
REQ-011 out_b  out  WIDTH  operand b.
REQ-012 out_sel  out  1  AND/OR select for downstream (1 = AND, 0 = OR).
REQ-013 busy  out  1  high while state is RUN.
REQ-014 done  out  1  one-cycle pulse on normal run completion.
REQ-015 txn_cnt  out  8  transfers completed in current/last run.

Function
REQ-016 LFSR SHALL be 16-bit Galois: if lfsr[0], next = (lfsr >> 1) ^ 16'hB400, else next = lfsr >> 1.
REQ-017 LFSR SHALL advance exactly once per operand load and at no other time; start SHALL NOT reseed it.
REQ-018 Operand load SHALL register out_a = lfsr[WIDTH-1:0], out_b = lfsr[2*WIDTH-1:WIDTH], out_sel = lfsr[15] from the pre-advance LFSR value.
REQ-019 FSM states IDLE, RUN, DONE; IDLE->RUN on start (first operand loaded, out_valid=1, txn_cnt=0 on the next edge).
REQ-020 In RUN, transfer = out_valid & out_ready; each transfer SHALL increment txn_cnt.
REQ-021 Transfer with txn_cnt < NUM_TXN-1: load next operand on the same edge, out_valid stays 1 (back-to-back, one operand per cycle).
REQ-022 Transfer with txn_cnt == NUM_TXN-1: RUN->DONE, out_valid=0, no load.
REQ-023 While out_valid & !out_ready, out_a/out_b/out_sel SHALL hold stable and LFSR SHALL hold.
REQ-024 DONE SHALL last exactly one cycle with done=1, then ->IDLE; txn_cnt holds until next start.
REQ-025 abort in RUN: ->IDLE, out_valid=0, no done pulse; a coincident transfer SHALL still be counted, no new load.
REQ-026 start outside IDLE and abort outside RUN SHALL be ignored; start and abort together in IDLE: start wins.
REQ-027 out_a/out_b/out_sel SHALL retain last loaded value when out_valid=0.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, lfsr=SEED, out_valid=0, out_a=0, out_b=0, out_sel=0, busy=0, done=0, txn_cnt=0.
REQ-029 Reset asserted mid-run SHALL discard the run; first run after release SHALL reproduce the post-reset sequence.

Structure
REQ-030 Package rog_pkg SHALL hold the state enum (IDLE, RUN, DONE) and constant LFSR_TAPS = 16'hB400.
REQ-031 LFSR SHALL be a sub-module lfsr16 (ports clk, rst_n, step, seed parameter, value); FSM, counter and output registers in rand_operand_gen.

Verification
REQ-032 Reset, start, out_ready=1, defaults: operands (a,b,sel) = (1,0,1), (0,0,1), (0,2,0) on first three valid cycles; done pulses one cycle after 8th transfer; txn_cnt=8.
REQ-033 Backpressure: out_ready low 5 cycles after first valid -> outputs and LFSR frozen, second operand still (0,0,1).
REQ-034 abort at txn_cnt=3 with coincident transfer -> txn_cnt=4, out_valid=0 next cycle, no done, busy=0.
REQ-035 rst_n pulsed low mid-run at txn_cnt=5 -> all outputs 0 asynchronously; next run's first operand (1,0,1).
REQ-036 Second start after completed run without reset -> first operand equals LFSR value after 8 steps from 16'hACE1 (continuation, not reseed); start during RUN has no effect.
REQ-037 NUM_TXN=1, WIDTH=7: single transfer -> DONE, done pulse, out_a = 7'h61, out_b = 7'h59.
